// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding and load-use detect.
// Optional perf counters are enabled with PIPE_HAZARD_PERF_EN.
package pipe_hazard_ctrl_pkg;

  localparam int PHC_STATE_W = 2;

  typedef enum logic [PHC_STATE_W-1:0] {
    PHC_RUN     = 2'd0,
    PHC_FLUSH   = 2'd1,
    PHC_MD_WAIT = 2'd2
  } phc_state_e;

  // A load writing x0 can never create a dependency.
  function automatic logic lu_hit(
    input logic       is_load,
    input logic       wen,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       rs1_used,
    input logic [4:0] rs2,
    input logic       rs2_used
  );
    return is_load & wen & (rd != 5'd0) &
           ((rs1_used & (rs1 == rd)) | (rs2_used & (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute <-> hazard controller signal bundle.
// Perf counter outputs exist only when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if #(parameter int ADDR_W = 32);
  logic              jump_en_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              ex_is_load_i;
  logic [4:0]        ex_rd_addr_i;
  logic              ex_reg_wen_i;
  logic [4:0]        id_rs1_addr_i;
  logic              id_rs1_used_i;
  logic [4:0]        id_rs2_addr_i;
  logic              id_rs2_used_i;
  logic              md_start_i;
  logic              md_done_i;

  logic              pc_hold_o;
  logic              jump_en_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic              if_id_hold_o;
  logic              if_id_flush_o;
  logic              id_ex_hold_o;
  logic              id_ex_flush_o;
  logic              md_timeout_o;
  logic [1:0]        state_o;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]       perf_lu_cnt_o;
  logic [31:0]       perf_flush_cnt_o;
  logic [31:0]       perf_md_cnt_o;
`endif

  modport master (
    output jump_en_i, jump_addr_i, ex_is_load_i, ex_rd_addr_i, ex_reg_wen_i,
           id_rs1_addr_i, id_rs1_used_i, id_rs2_addr_i, id_rs2_used_i,
           md_start_i, md_done_i,
    input  pc_hold_o, jump_en_o, jump_addr_o, if_id_hold_o, if_id_flush_o,
           id_ex_hold_o, id_ex_flush_o, md_timeout_o, state_o
`ifdef PIPE_HAZARD_PERF_EN
    , input perf_lu_cnt_o, perf_flush_cnt_o, perf_md_cnt_o
`endif
  );

  modport slave (
    input  jump_en_i, jump_addr_i, ex_is_load_i, ex_rd_addr_i, ex_reg_wen_i,
           id_rs1_addr_i, id_rs1_used_i, id_rs2_addr_i, id_rs2_used_i,
           md_start_i, md_done_i,
    output pc_hold_o, jump_en_o, jump_addr_o, if_id_hold_o, if_id_flush_o,
           id_ex_hold_o, id_ex_flush_o, md_timeout_o, state_o
`ifdef PIPE_HAZARD_PERF_EN
    , output perf_lu_cnt_o, perf_flush_cnt_o, perf_md_cnt_o
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl_wdt.sv
// Mul/div watchdog: counts while enabled, expire asserts at LIMIT-1.
module pipe_hazard_wdt #(
  parameter int LIMIT = 64,
  parameter int W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expire = (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: redirect flush, load-use bubble, mul/div freeze.
// Define PIPE_HAZARD_PERF_EN to add saturating perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int MD_TIMEOUT   = 64
) (
  input  logic clk,
  input  logic rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  phc_state_e  state, state_nxt;
  logic [2:0]  fcnt, fcnt_nxt;
  logic        lu, md_go, wdt_clr, wdt_en, wdt_exp;

  logic              pc_hold, jump_en, if_id_hold, if_id_flush;
  logic              id_ex_hold, id_ex_flush, md_timeout;
  logic [ADDR_W-1:0] jump_addr;

  assign lu = lu_hit(bus.ex_is_load_i, bus.ex_reg_wen_i, bus.ex_rd_addr_i,
                     bus.id_rs1_addr_i, bus.id_rs1_used_i,
                     bus.id_rs2_addr_i, bus.id_rs2_used_i);

  // mul/div only launches from RUN, and a jump in the same cycle wins
  assign md_go = (state == PHC_RUN) & ~bus.jump_en_i & bus.md_start_i;

  // Watchdog counts from the launch cycle so expire lines up with cycle MD_TIMEOUT-1
  assign wdt_en  = md_go | (state == PHC_MD_WAIT);
  assign wdt_clr = (state == PHC_MD_WAIT) ? (bus.md_done_i | wdt_exp) : ~md_go;

  pipe_hazard_wdt #(.LIMIT(MD_TIMEOUT), .W(8)) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .clr    (wdt_clr),
    .en     (wdt_en),
    .expire (wdt_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PHC_RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    case (state)
      PHC_RUN: begin
        if (bus.jump_en_i) begin
          state_nxt = (FLUSH_CYCLES > 1) ? PHC_FLUSH : PHC_RUN;
          fcnt_nxt  = FLUSH_LOAD;
        end else if (bus.md_start_i) begin
          state_nxt = PHC_MD_WAIT;
        end
      end
      PHC_FLUSH: begin
        if (bus.jump_en_i) begin
          fcnt_nxt = FLUSH_LOAD;
        end else begin
          fcnt_nxt = fcnt - 3'd1;
          if (fcnt == 3'd1) state_nxt = PHC_RUN;
        end
      end
      PHC_MD_WAIT: begin
        if (bus.md_done_i | wdt_exp) state_nxt = PHC_RUN;
      end
      default: state_nxt = PHC_RUN;
    endcase
  end

  // Outputs are forced low while reset is held, independent of the inputs
  always_comb begin
    pc_hold     = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = '0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_hold  = 1'b0;
    id_ex_flush = 1'b0;
    md_timeout  = 1'b0;
    if (rst) begin
      case (state)
        PHC_RUN: begin
          if (bus.jump_en_i) begin
            jump_en     = 1'b1;
            jump_addr   = bus.jump_addr_i;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (bus.md_start_i) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            id_ex_hold = 1'b1;
          end else if (lu) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        PHC_FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (bus.jump_en_i) begin
            jump_en   = 1'b1;
            jump_addr = bus.jump_addr_i;
          end
        end
        PHC_MD_WAIT: begin
          if (!(bus.md_done_i | wdt_exp)) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            id_ex_hold = 1'b1;
          end
          md_timeout = wdt_exp & ~bus.md_done_i;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_hold_o     = pc_hold;
  assign bus.jump_en_o     = jump_en;
  assign bus.jump_addr_o   = jump_addr;
  assign bus.if_id_hold_o  = if_id_hold;
  assign bus.if_id_flush_o = if_id_flush;
  assign bus.id_ex_hold_o  = id_ex_hold;
  assign bus.id_ex_flush_o = id_ex_flush;
  assign bus.md_timeout_o  = md_timeout;
  assign bus.state_o       = state;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] lu_cnt, flush_cnt, md_cnt;
  logic        lu_bubble;

  assign lu_bubble = (state == PHC_RUN) & ~bus.jump_en_i & ~bus.md_start_i & lu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_cnt    <= '0;
      flush_cnt <= '0;
      md_cnt    <= '0;
    end else begin
      if (lu_bubble && lu_cnt != '1)                  lu_cnt    <= lu_cnt + 1'b1;
      if (jump_en && flush_cnt != '1)                 flush_cnt <= flush_cnt + 1'b1;
      if (state == PHC_MD_WAIT && md_cnt != '1)       md_cnt    <= md_cnt + 1'b1;
    end
  end

  assign bus.perf_lu_cnt_o    = lu_cnt;
  assign bus.perf_flush_cnt_o = flush_cnt;
  assign bus.perf_md_cnt_o    = md_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, MD_TIMEOUT=64).
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.ADDR_W(32)) bus();

  pipe_hazard_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2), .MD_TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [6:0]  ctl;   // pc_hold, jump_en, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, md_timeout
    logic [1:0]  st;
    logic [31:0] addr;
  } obs_t;

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_HOLD3 = 7'b1010100;
  localparam logic [6:0] C_LU    = 7'b1010010;
  localparam logic [6:0] C_FLUSH = 7'b0001010;
  localparam logic [6:0] C_JUMP  = 7'b0101010;
  localparam logic [6:0] C_TO    = 7'b0000001;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.ctl  = {bus.pc_hold_o, bus.jump_en_o, bus.if_id_hold_o, bus.if_id_flush_o,
              bus.id_ex_hold_o, bus.id_ex_flush_o, bus.md_timeout_o};
    o.st   = bus.state_o;
    o.addr = bus.jump_addr_o;
    return o;
  endfunction

  function automatic obs_t mk(input logic [6:0] ctl, input logic [1:0] st, input logic [31:0] addr);
    obs_t o;
    o.ctl = ctl; o.st = st; o.addr = addr;
    return o;
  endfunction

  task automatic idle_in();
    bus.jump_en_i     = 1'b0;
    bus.jump_addr_i   = '0;
    bus.ex_is_load_i  = 1'b0;
    bus.ex_rd_addr_i  = '0;
    bus.ex_reg_wen_i  = 1'b0;
    bus.id_rs1_addr_i = '0;
    bus.id_rs1_used_i = 1'b0;
    bus.id_rs2_addr_i = '0;
    bus.id_rs2_used_i = 1'b0;
    bus.md_start_i    = 1'b0;
    bus.md_done_i     = 1'b0;
  endtask

  task automatic rand_in();
    bus.jump_en_i     = 1'($urandom);
    bus.jump_addr_i   = $urandom;
    bus.ex_is_load_i  = 1'($urandom);
    bus.ex_rd_addr_i  = 5'($urandom);
    bus.ex_reg_wen_i  = 1'($urandom);
    bus.id_rs1_addr_i = 5'($urandom);
    bus.id_rs1_used_i = 1'($urandom);
    bus.id_rs2_addr_i = 5'($urandom);
    bus.id_rs2_used_i = 1'($urandom);
    bus.md_start_i    = 1'($urandom);
    bus.md_done_i     = 1'($urandom);
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic wen);
    bus.ex_is_load_i  = 1'b1;
    bus.ex_rd_addr_i  = rd;
    bus.ex_reg_wen_i  = wen;
    bus.id_rs1_addr_i = rs1;
    bus.id_rs1_used_i = u1;
    bus.id_rs2_addr_i = rs2;
    bus.id_rs2_used_i = u2;
  endtask

  // Inputs already driven just after posedge; sample at negedge, return just after next posedge
  task automatic step(input string tag, input obs_t e);
    obs_t x;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    chk(tag, 64'(observe()), 64'(x));
    @(posedge clk);
    #1;
  endtask

  task automatic wdt_run(input string tag);
    idle_in(); bus.md_start_i = 1'b1;
    step({tag, "_start"}, mk(C_HOLD3, 2'd0, 32'h0));
    idle_in();
    for (int i = 1; i < 63; i++) step({tag, "_wait"}, mk(C_HOLD3, 2'd2, 32'h0));
    step({tag, "_timeout"}, mk(C_TO, 2'd2, 32'h0));
    step({tag, "_after"}, mk(C_NONE, 2'd0, 32'h0));
  endtask

  initial begin
    obs_t x;
    // Reset held with random stimulus
    rand_in();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      rand_in();
      step("reset_outputs", mk(C_NONE, 2'd0, 32'h0));
    end
    idle_in();
    rst = 1'b1;
    step("release_idle", mk(C_NONE, 2'd0, 32'h0));
    step("release_idle2", mk(C_NONE, 2'd0, 32'h0));

    // Load-use on rs2, then the load has moved on
    set_lu(5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1);
    step("lu_rs2", mk(C_LU, 2'd0, 32'h0));
    idle_in();
    step("lu_after", mk(C_NONE, 2'd0, 32'h0));
    set_lu(5'd9, 5'd9, 1'b1, 5'd2, 1'b0, 1'b1);
    step("lu_rs1", mk(C_LU, 2'd0, 32'h0));
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
    step("lu_rd0", mk(C_NONE, 2'd0, 32'h0));
    set_lu(5'd5, 5'd1, 1'b0, 5'd5, 1'b1, 1'b0);
    step("lu_nowen", mk(C_NONE, 2'd0, 32'h0));
    set_lu(5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b1);
    step("lu_unused", mk(C_NONE, 2'd0, 32'h0));

    // Jump with a simultaneous load-use; extra LU/md_start during FLUSH ignored
    set_lu(5'd5, 5'd1, 1'b0, 5'd5, 1'b1, 1'b1);
    bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h8000_0040;
    step("jump_issue", mk(C_JUMP, 2'd0, 32'h8000_0040));
    bus.jump_en_i = 1'b0; bus.jump_addr_i = '0; bus.md_start_i = 1'b1;
    step("jump_flush", mk(C_FLUSH, 2'd1, 32'h0));
    idle_in();
    step("jump_done", mk(C_NONE, 2'd0, 32'h0));

    // Redirect restarted while flushing
    bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h0000_1000;
    step("rejump_a", mk(C_JUMP, 2'd0, 32'h0000_1000));
    bus.jump_addr_i = 32'h0000_2000;
    step("rejump_b", mk(C_JUMP, 2'd1, 32'h0000_2000));
    idle_in();
    step("rejump_flush", mk(C_FLUSH, 2'd1, 32'h0));
    step("rejump_done", mk(C_NONE, 2'd0, 32'h0));

    // Mul/div beats load-use; done after 10 cycles; jump ignored while frozen
    set_lu(5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1);
    bus.md_start_i = 1'b1;
    step("md_start", mk(C_HOLD3, 2'd0, 32'h0));
    idle_in();
    for (int i = 1; i < 10; i++) begin
      bus.jump_en_i = (i == 3); bus.jump_addr_i = 32'hdead_beef;
      step("md_wait", mk(C_HOLD3, 2'd2, 32'h0));
    end
    idle_in(); bus.md_done_i = 1'b1;
    step("md_done", mk(C_NONE, 2'd2, 32'h0));
    idle_in();
    step("md_exit", mk(C_NONE, 2'd0, 32'h0));

    // Watchdog expiry
    wdt_run("wdt");

    // Asynchronous reset during MD_WAIT
    idle_in(); bus.md_start_i = 1'b1;
    step("rmd_start", mk(C_HOLD3, 2'd0, 32'h0));
    idle_in();
    for (int i = 1; i < 5; i++) step("rmd_wait", mk(C_HOLD3, 2'd2, 32'h0));
    rst = 1'b0;
    #1;
    exp_q.push_back(mk(C_NONE, 2'd0, 32'h0));
    x = exp_q.pop_front();
    chk("rmd_async", 64'(observe()), 64'(x));
    @(posedge clk); #1;
    step("rmd_held", mk(C_NONE, 2'd0, 32'h0));
    rst = 1'b1;
    step("rmd_release", mk(C_NONE, 2'd0, 32'h0));
    wdt_run("wdt2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage RV core.
- Sequences the IF/ID and ID/EX pipeline registers: drives their hold (freeze) and flush (load default NOP/zero) controls, redirects the PC on taken jumps/branches, and inserts load-use bubbles.
- Freezes the front end while a multi-cycle mul/div unit in EX is busy.
- Sits beside the decode/execute stages; all pipeline-register control inputs come from here.

Parameters:
- ADDR_W, 32, width of PC/jump address.
- FLUSH_CYCLES, 1, cycles IF/ID stays flushed after a redirect (covers fetch latency); legal range 1..7.
- MD_TIMEOUT, 64, max cycles in MD_WAIT before the watchdog forces exit; legal range 2..255.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-low
- jump_en_i  in  1  EX resolved taken jump/branch
- jump_addr_i  in  ADDR_W  redirect target
- ex_is_load_i  in  1  instruction in EX is a load
- ex_rd_addr_i  in  5  EX destination register
- ex_reg_wen_i  in  1  EX writes rd
- id_rs1_addr_i  in  5  ID source register 1
- id_rs1_used_i  in  1  ID reads rs1
- id_rs2_addr_i  in  5  ID source register 2
- id_rs2_used_i  in  1  ID reads rs2
- md_start_i  in  1  EX issued a multi-cycle mul/div
- md_done_i  in  1  mul/div result valid
- pc_hold_o  out  1  PC keeps its value
- jump_en_o  out  1  PC loads jump_addr_o
- jump_addr_o  out  ADDR_W  PC redirect target
- if_id_hold_o  out  1  IF/ID freezes
- if_id_flush_o  out  1  IF/ID loads NOP
- id_ex_hold_o  out  1  ID/EX freezes
- id_ex_flush_o  out  1  ID/EX loads NOP/zero (bubble)
- md_timeout_o  out  1  one-cycle pulse on watchdog exit
- state_o  out  2  current FSM state

Behaviour:
- States: RUN=0, FLUSH=1, MD_WAIT=2. The encoding is visible on state_o.
- Reset (rst low, asynchronous):
  - state=RUN, flush counter=0, watchdog=0.
  - Every output is 0, including jump_addr_o.
- Control outputs are combinational from state and inputs (zero latency). State and counters update on the posedge of clk.
- Load-use hazard, LU:
  - LU = ex_is_load_i & ex_reg_wen_i & ex_rd_addr_i!=0 & ((id_rs1_used_i & rs1==rd) | (id_rs2_used_i & rs2==rd)).
  - A register-0 destination never stalls.
- Priority within a cycle: jump > md_start > LU.
- RUN state:
  - If jump_en_i: jump_en_o=1, jump_addr_o=jump_addr_i, if_id_flush_o=1, id_ex_flush_o=1. Next state is FLUSH if FLUSH_CYCLES>1, otherwise RUN. Flush counter loads FLUSH_CYCLES-1. Any LU or md_start that cycle is ignored.
  - Else if md_start_i: pc_hold_o, if_id_hold_o and id_ex_hold_o are all 1. Next state MD_WAIT, watchdog=0.
  - Else if LU: pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1. This is exactly one bubble. No state change; the next cycle re-evaluates LU, which is false because the load has moved to MEM.
  - Otherwise all control outputs are 0.
- FLUSH state:
  - if_id_flush_o=1 and id_ex_flush_o=1. Flush counter decrements.
  - Return to RUN on the cycle the counter reads 1.
  - A jump_en_i arriving in FLUSH restarts the redirect: jump_en_o=1, new target, counter reloads.
- MD_WAIT state:
  - pc_hold_o, if_id_hold_o and id_ex_hold_o are 1. Watchdog increments every cycle.
  - md_done_i: holds drop in the same cycle; next state RUN.
  - Watchdog reaching MD_TIMEOUT-1 without md_done_i: md_timeout_o pulses 1 cycle, holds drop, next state RUN.
  - jump_en_i is ignored in MD_WAIT because EX is frozen.
- hold and flush are never both 1 for the same register. Flush wins by construction.
- Reset asserted mid-operation aborts any state immediately. There is no pending redirect after release.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined: adds 32-bit outputs perf_lu_cnt_o, perf_flush_cnt_o and perf_md_cnt_o. These count load-use bubbles, redirects, and MD_WAIT cycles respectively. They reset to 0 and saturate at all-ones.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- The shared defines header gains state encodings `PHC_RUN/`PHC_FLUSH/`PHC_MD_WAIT and `PHC_STATE_W=2. `INST_NOP is reused from the same header.
- One sub-module, pipe_hazard_wdt: the MD_TIMEOUT watchdog counter with clear/enable inputs and an expire output.

Test Plan:
- Reset: rst low with random inputs -> all outputs 0, state_o=0. Release -> RUN with no spurious hold.
- Load-use: ex_is_load_i=1, ex_rd_addr_i=5, id_rs2_addr_i=5, id_rs2_used_i=1 -> one cycle of pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1, then all 0. The same stimulus with rd=0 -> no stall.
- Jump: jump_en_i=1, jump_addr_i=0x8000_0040, FLUSH_CYCLES=2 -> jump_en_o=1 with matching address, both flushes 1 for 2 cycles, state_o 0->1->0. Simultaneous LU is ignored.
- Mul/div: md_start_i, then md_done_i 10 cycles later -> all three holds 1 for cycles 0..9, 0 on the done cycle, state returns to 0.
- Watchdog: md_start_i with md_done_i never asserted, MD_TIMEOUT=64 -> md_timeout_o pulse at cycle 63, holds drop, state RUN.
- Reset mid-MD_WAIT: rst low at cycle 5 -> outputs 0 immediately (asynchronous). After release, state RUN and watchdog cleared.
